minibyte_regram_arb: RTL and testbench

Two-requester arbiter and access sequencer for the 8-byte register RAM (`reg_ram_8B`) in the MiniByte CPU. It sits between the register RAM and two clients:

- **Port A**: the CPU control unit.
- **Port B**: the debug/host interface.

It serialises their read/write requests onto the RAM's single address/data/we/en port and returns registered read data with a one-cycle acknowledge. Arbitration is round-robin by default; fixed priority is available as a compile option.

---
 rtl/minibyte_regarb_pkg.sv | 20 ++
 rtl/minibyte_rr_arb2.sv | 39 +++
 rtl/minibyte_regram_arb.sv | 132 +++++++++++++
 tb/tb_minibyte_regram_arb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/minibyte_regarb_pkg.sv
// minibyte_regarb_pkg
// Shared types and constants for the MiniByte register-RAM arbiter.
//   state_e      : sequencer states (IDLE -> ACCESS -> DONE -> IDLE)
//   PORT_A/B     : grant identifiers (A = CPU control unit, B = debug/host)
//   REGARB_AW/DW : register RAM address and data widths
package minibyte_regarb_pkg;

  localparam int REGARB_AW = 3;
  localparam int REGARB_DW = 8;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/minibyte_rr_arb2.sv
// minibyte_rr_arb2
// Combinational two-way winner select for the register-RAM arbiter.
// Ports:
//   a_req, b_req : in  request levels from port A and port B
//   ptr          : in  preferred port (PORT_A / PORT_B), used on contention
//   any_req      : out at least one request is present
//   winner       : out selected port, meaningful only while any_req = 1
// Build option MINIBYTE_REGARB_PRIO_EN: when defined, port A always wins
// on contention and ptr is ignored; when undefined, ptr decides.
module minibyte_rr_arb2
  import minibyte_regarb_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic ptr,
  output logic any_req,
  output logic winner
);

  assign any_req = a_req | b_req;

`ifdef MINIBYTE_REGARB_PRIO_EN
  // Fixed priority: B only wins when A is silent.
  logic unused_ptr;
  assign unused_ptr = ptr;
  assign winner     = a_req ? PORT_A : PORT_B;
`else
  // Round-robin: a lone requester wins outright, otherwise the preferred one.
  always_comb begin
    winner = PORT_A;
    if (a_req && b_req) begin
      winner = ptr;
    end else if (b_req) begin
      winner = PORT_B;
    end
  end
`endif

endmodule

// File: rtl/minibyte_regram_arb.sv
// minibyte_regram_arb
// Serialises two clients (A = CPU control unit, B = debug/host) onto the
// single port of the 8-byte register RAM. Each access takes three cycles:
// IDLE (arbitrate and latch), ACCESS (drive RAM), DONE (ack + read data).
// Ports:
//   clk_in, rst_in                 : clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata      : port A request, write flag, address, data
//   a_ack/a_rdata                  : port A one-cycle ack and read data
//   b_*                            : same set for port B
//   ram_en/ram_we/ram_addr/ram_wdata : to the register RAM
//   ram_rdata                      : from the register RAM (combinational)
// Build option MINIBYTE_REGARB_PRIO_EN selects fixed priority (A first)
// inside minibyte_rr_arb2; the default build is round-robin.
module minibyte_regram_arb
  import minibyte_regarb_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [REGARB_AW-1:0] a_addr,
  input  logic [REGARB_DW-1:0] a_wdata,
  output logic                 a_ack,
  output logic [REGARB_DW-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [REGARB_AW-1:0] b_addr,
  input  logic [REGARB_DW-1:0] b_wdata,
  output logic                 b_ack,
  output logic [REGARB_DW-1:0] b_rdata,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [REGARB_AW-1:0] ram_addr,
  output logic [REGARB_DW-1:0] ram_wdata,
  input  logic [REGARB_DW-1:0] ram_rdata
);

  state_e               state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 ptr_q, ptr_d;
  logic                 hold_we_q, hold_we_d;
  logic [REGARB_AW-1:0] hold_addr_q, hold_addr_d;
  logic [REGARB_DW-1:0] hold_wdata_q, hold_wdata_d;
  logic [REGARB_DW-1:0] rdata_q, rdata_d;

  logic any_req;
  logic winner;

  minibyte_rr_arb2 u_arb (
    .a_req   (a_req),
    .b_req   (b_req),
    .ptr     (ptr_q),
    .any_req (any_req),
    .winner  (winner)
  );

  always_comb begin
    // NOTE: every signal gets a hold-value default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    hold_we_d    = hold_we_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    rdata_d      = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = winner;
          if (winner == PORT_B) begin
            hold_we_d    = b_we;
            hold_addr_d  = b_addr;
            hold_wdata_d = b_wdata;
          end else begin
            hold_we_d    = a_we;
            hold_addr_d  = a_addr;
            hold_wdata_d = a_wdata;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // The RAM returns 0 while writing; force it anyway so writes always
        // hand back a clean 8'h00.
        rdata_d = hold_we_q ? '0 : ram_rdata;
        state_d = DONE;
      end
      DONE: begin
        ptr_d   = ~grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst_in) begin
      state_q      <= IDLE;
      grant_q      <= PORT_A;
      ptr_q        <= PORT_A;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      hold_we_q    <= hold_we_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // RAM side: enable only in ACCESS; address/data come straight from the
  // holding registers, which are cleared by reset.
  assign ram_en    = (state_q == ACCESS);
  assign ram_we    = ram_en & hold_we_q;
  assign ram_addr  = hold_addr_q;
  assign ram_wdata = hold_wdata_q;

  assign a_ack   = (state_q == DONE) && (grant_q == PORT_A);
  assign b_ack   = (state_q == DONE) && (grant_q == PORT_B);
  assign a_rdata = rdata_q;
  assign b_rdata = rdata_q;

endmodule

// File: tb/tb_minibyte_regram_arb.sv
// tb_minibyte_regram_arb
// Self-checking bench for minibyte_regram_arb. Includes a behavioural model
// of the register RAM (reg_ram_8B) and a transaction-level reference model:
// each grant is taken in the first free cycle with a request, occupies
// three cycles, and its result is computed from a reference memory array.
module tb_minibyte_regram_arb;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       a_req, a_we, b_req, b_we;
  logic [2:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_ack, b_ack;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_en, ram_we;
  logic [2:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;

  always #5 clk_in = ~clk_in;

  minibyte_regram_arb dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .b_rdata   (b_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Register RAM environment model: combinational read, write on the edge,
  // cleared by the shared reset.
  logic [7:0] tb_ram [8];

  always_comb begin
    ram_rdata = 8'h00;
    if (ram_en && !ram_we) ram_rdata = tb_ram[ram_addr];
  end

  always @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 8; i++) tb_ram[i] <= 8'h00;
    end else if (ram_en && ram_we) begin
      tb_ram[ram_addr] <= ram_wdata;
    end
  end

  // Reference model state
  int         n_checks = 0;
  int         n_fail   = 0;
  int         age      = -1;   // cycles since the current grant, -1 = none
  bit         pref     = 1'b0; // preferred port, 0 = A
  bit         last_rst = 1'b1;
  bit         t_port, t_we;
  bit [2:0]   t_addr;
  bit [7:0]   t_wdata, t_rdata;
  bit [7:0]   ref_mem [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check the outputs of the current cycle, drive the
  // inputs sampled at its closing edge, then advance the reference model.
  task automatic step(input bit rst,
                      input bit ar, input bit awe, input bit [2:0] aad, input bit [7:0] awd,
                      input bit br, input bit bwe, input bit [2:0] bad, input bit [7:0] bwd);
    bit pick;
    @(negedge clk_in);
    if (last_rst) begin
      check("rst_a_rdata", a_rdata, 0);
      check("rst_b_rdata", b_rdata, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_wdata", ram_wdata, 0);
    end
    check("a_ack", a_ack, (age == 2 && t_port == 1'b0) ? 1 : 0);
    check("b_ack", b_ack, (age == 2 && t_port == 1'b1) ? 1 : 0);
    check("ram_en", ram_en, (age == 1) ? 1 : 0);
    if (age == 1) begin
      check("ram_we", ram_we, t_we);
      check("ram_addr", ram_addr, t_addr);
      if (t_we) check("ram_wdata", ram_wdata, t_wdata);
    end else begin
      check("ram_we_idle", ram_we, 0);
    end
    if (age == 2) begin
      if (t_port) check("b_rdata", b_rdata, t_rdata);
      else        check("a_rdata", a_rdata, t_rdata);
    end

    rst_in = rst;
    a_req = ar; a_we = awe; a_addr = aad; a_wdata = awd;
    b_req = br; b_we = bwe; b_addr = bad; b_wdata = bwd;

    if (rst) begin
      age  = -1;
      pref = 1'b0;
      for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
    end else if (age == -1) begin
      if (ar || br) begin
`ifdef MINIBYTE_REGARB_PRIO_EN
        pick = ar ? 1'b0 : 1'b1;
`else
        pick = (ar && br) ? pref : br;
`endif
        t_port  = pick;
        t_we    = pick ? bwe : awe;
        t_addr  = pick ? bad : aad;
        t_wdata = pick ? bwd : awd;
        t_rdata = t_we ? 8'h00 : ref_mem[t_addr];
        if (t_we) ref_mem[t_addr] = t_wdata;
        age = 1;
      end
    end else if (age == 2) begin
      pref = ~t_port;
      age  = -1;
    end else begin
      age++;
    end
    last_rst = rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00);
  endtask

  initial begin
    rst_in = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;

    // Reset with both requests high, then first grant goes to A
    step(1, 1, 0, 3'd0, 8'h00, 1, 0, 3'd0, 8'h00);
    step(1, 1, 0, 3'd0, 8'h00, 1, 0, 3'd0, 8'h00);
    step(0, 1, 0, 3'd0, 8'h00, 1, 0, 3'd0, 8'h00);
    idle(3);

    // Single write then read on port A
    step(0, 1, 1, 3'd3, 8'hA5, 0, 0, 3'd0, 8'h00);
    idle(2);
    step(0, 1, 0, 3'd3, 8'h00, 0, 0, 3'd0, 8'h00);
    idle(3);

    // Preload and contention: both ports read continuously
    step(0, 1, 1, 3'd1, 8'h11, 0, 0, 3'd0, 8'h00);
    idle(2);
    step(0, 0, 0, 3'd0, 8'h00, 1, 1, 3'd2, 8'h22);
    idle(2);
    for (int i = 0; i < 15; i++) step(0, 1, 0, 3'd1, 8'h00, 1, 0, 3'd2, 8'h00);
    for (int i = 0; i < 6; i++)  step(0, 0, 0, 3'd1, 8'h00, 1, 0, 3'd2, 8'h00);
    idle(3);

    // Mid-access reset on a B write, then read it back
    step(0, 0, 0, 3'd0, 8'h00, 1, 1, 3'd7, 8'h3C);
    step(1, 0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00);
    idle(1);
    step(0, 0, 0, 3'd0, 8'h00, 1, 0, 3'd7, 8'h00);
    idle(3);

    // Late address change during ACCESS
    step(0, 1, 1, 3'd4, 8'h44, 0, 0, 3'd0, 8'h00);
    idle(2);
    step(0, 1, 1, 3'd5, 8'h55, 0, 0, 3'd0, 8'h00);
    idle(2);
    step(0, 1, 0, 3'd4, 8'h00, 0, 0, 3'd0, 8'h00);
    step(0, 0, 0, 3'd5, 8'h00, 0, 0, 3'd0, 8'h00);
    idle(2);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(63) == 0),
           1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom));
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
